// File: rtl/jt7759_romcache.sv
// Two-line, 32-bit read cache between the JT7759 byte ROM port and a shared
// memory arbiter, with optional next-line prefetch and flush support.
module jt7759_romcache #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_cs,
    input  logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_ok,
    input  logic        flush,
    output logic        mem_cs,
    output logic [14:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_ok
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DFILL = 2'd1,
        PFILL = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] line_data_reg [2];
    logic [14:0] line_tag_reg  [2];
    logic [1:0]  valid_reg, valid_next;
    logic        mru_reg;
    logic        fill_line_reg, fill_line_next;
    logic [14:0] fill_tag_reg, fill_tag_next;
    logic        discard_reg, discard_next;
    logic        mem_cs_reg, mem_cs_next;
    logic [14:0] mem_addr_reg, mem_addr_next;
    logic        rom_ok_reg;
    logic [7:0]  rom_data_reg;

    logic [14:0] req_tag, pf_tag;
    logic [1:0]  match, pf_match;
    logic        hit, hit_line, pf_want, line_wr;
    logic [31:0] hit_word;

    assign req_tag = rom_addr[16:2];
    assign pf_tag  = line_tag_reg[mru_reg] + 15'd1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            assign match[gi]    = valid_reg[gi] && (line_tag_reg[gi] == req_tag);
            assign pf_match[gi] = valid_reg[gi] && (line_tag_reg[gi] == pf_tag);
        end
    endgenerate

    assign hit      = rom_cs && (|match);
    assign hit_line = !match[0];
    assign hit_word = line_data_reg[hit_line];
    // Prefetch only off a live line, and never while the client is stepping onto
    // the line the prefetch would overwrite (mru has not caught up yet).
    assign pf_want  = PREFETCH && valid_reg[mru_reg] && !(|pf_match)
                      && !(hit && (hit_line != mru_reg));

    always_comb begin
        state_next     = state_reg;
        valid_next     = flush ? 2'b00 : valid_reg;
        fill_line_next = fill_line_reg;
        fill_tag_next  = fill_tag_reg;
        discard_next   = discard_reg || flush;
        mem_cs_next    = mem_cs_reg;
        mem_addr_next  = mem_addr_reg;
        line_wr        = 1'b0;
        case (state_reg)
            IDLE: begin
                discard_next = 1'b0;
                if (!flush) begin
                    if (rom_cs && !hit) begin
                        state_next     = DFILL;
                        mem_cs_next    = 1'b1;
                        mem_addr_next  = req_tag;
                        fill_tag_next  = req_tag;
                        fill_line_next = !mru_reg;
                    end else if (pf_want) begin
                        state_next     = PFILL;
                        mem_cs_next    = 1'b1;
                        mem_addr_next  = pf_tag;
                        fill_tag_next  = pf_tag;
                        fill_line_next = !mru_reg;
                    end
                end
            end
            DFILL, PFILL: begin
                // A demand for the tag already being prefetched simply waits here.
                if (mem_ok) begin
                    line_wr      = 1'b1;
                    mem_cs_next  = 1'b0;
                    state_next   = IDLE;
                    discard_next = 1'b0;
                    if (!flush && !discard_reg) begin
                        valid_next[fill_line_reg] = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            valid_reg     <= 2'b00;
            mru_reg       <= 1'b0;
            fill_line_reg <= 1'b0;
            fill_tag_reg  <= 15'd0;
            discard_reg   <= 1'b0;
            mem_cs_reg    <= 1'b0;
            mem_addr_reg  <= 15'd0;
            rom_ok_reg    <= 1'b0;
            rom_data_reg  <= 8'd0;
        end else begin
            state_reg     <= state_next;
            valid_reg     <= valid_next;
            fill_line_reg <= fill_line_next;
            fill_tag_reg  <= fill_tag_next;
            discard_reg   <= discard_next;
            mem_cs_reg    <= mem_cs_next;
            mem_addr_reg  <= mem_addr_next;
            rom_ok_reg    <= hit && !flush;
            if (hit) begin
                rom_data_reg <= hit_word[{rom_addr[1:0], 3'b000} +: 8];
                mru_reg      <= hit_line;
            end
        end
    end

    // Line payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            line_data_reg[fill_line_reg] <= mem_data;
            line_tag_reg[fill_line_reg]  <= fill_tag_reg;
        end
    end

    assign rom_ok   = rom_ok_reg;
    assign rom_data = rom_data_reg;
    assign mem_cs   = mem_cs_reg;
    assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_jt7759_romcache.sv
// Self-checking bench for jt7759_romcache: directed scenarios plus randomized
// reads checked against a word-addressed memory model.
`timescale 1ns/1ps
module tb_jt7759_romcache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_cs = 1'b0;
    logic [16:0] rom_addr = 17'd0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        flush = 1'b0;
    logic        mem_cs;
    logic [14:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ok;
    logic        auto_ok = 1'b0, man_ok = 1'b0;
    logic [31:0] auto_data = 32'd0, man_data = 32'd0;

    int          n_vec = 0, n_err = 0;
    bit          mem_auto = 1'b1;
    int          mem_lat = 4;
    int          unstable = 0;
    logic [31:0] mem_words [32768];
    logic [14:0] req_q [$];

    assign mem_ok   = auto_ok | man_ok;
    assign mem_data = man_ok ? man_data : auto_data;

    always #5 clk = ~clk;

    jt7759_romcache #(.PREFETCH(1'b1)) dut (
        .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .flush(flush),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok)
    );

    // Memory arbiter model: acks each request mem_lat cycles after it is seen.
    initial begin : responder
        int cnt;
        logic [14:0] held;
        cnt = 0;
        held = 15'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                auto_ok = 1'b0; cnt = 0;
            end else if (auto_ok) begin
                auto_ok = 1'b0; cnt = 0;
            end else if (mem_auto && mem_cs) begin
                cnt++;
                if (cnt == 1) begin
                    held = mem_addr;
                    req_q.push_back(mem_addr);
                end else if (mem_addr !== held) begin
                    unstable++;
                end
                if (cnt >= mem_lat) begin
                    auto_data = mem_words[mem_addr];
                    auto_ok   = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] ref_byte(input logic [16:0] a);
        logic [31:0] w;
        w = mem_words[a[16:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic read_byte(input logic [16:0] a, output int lat, output logic [7:0] d);
        rom_addr = a;
        rom_cs   = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rom_ok && lat < 200);
        d      = rom_data;
        rom_cs = 1'b0;
        $display("rd %05h -> %02h lat %0d", a, d, lat);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rom_cs = 1'b0; flush = 1'b0; man_ok = 1'b0; mem_auto = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        req_q.delete();
    endtask

    task automatic test_reset();
        tick(2);
        n_vec++; if (rom_ok !== 1'b0) begin n_err++; $display("FAIL reset_rom_ok: got %b want 0", rom_ok); end
        n_vec++; if (rom_data !== 8'h00) begin n_err++; $display("FAIL reset_rom_data: got %h want 00", rom_data); end
        n_vec++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
        n_vec++; if (mem_addr !== 15'h0000) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        rst = 1'b0;
        tick(3);
        n_vec++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL reset_idle_mem_cs: got %b want 0", mem_cs); end
        req_q.delete();
    endtask

    task automatic test_cold_miss();
        int lat;
        logic [7:0] d;
        logic [14:0] first;
        mem_lat = 4;
        mem_words[1] = 32'h44332211;
        read_byte(17'h00005, lat, d);
        first = (req_q.size() > 0) ? req_q[0] : 15'h7abc;
        n_vec++; if (first !== 15'h0001) begin n_err++; $display("FAIL cold_mem_addr: got %h want 0001", first); end
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL cold_latency: got %0d want 6", lat); end
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL cold_data: got %h want 22", d); end
    endtask

    task automatic test_hit_after_fill();
        int lat, c;
        logic [7:0] d;
        read_byte(17'h00006, lat, d);
        c = 0;
        foreach (req_q[i]) if (req_q[i] == 15'h0001) c++;
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL hit_latency: got %0d want 1", lat); end
        n_vec++; if (d !== 8'h33) begin n_err++; $display("FAIL hit_data: got %h want 33", d); end
        n_vec++; if (c != 1) begin n_err++; $display("FAIL hit_refetch: tag 1 requested %0d times want 1", c); end
    endtask

    task automatic test_sequential();
        int lat, first_lat, stalls;
        logic [7:0] d;
        logic [14:0] exp_tags [4];
        do_reset();
        mem_lat = 5;
        stalls = 0;
        first_lat = 0;
        for (int a = 4; a <= 15; a++) begin
            read_byte(17'(a), lat, d);
            if (a == 4) first_lat = lat;
            else stalls += lat - 1;
            n_vec++; if (d !== ref_byte(17'(a))) begin n_err++; $display("FAIL seq_data: addr %05h got %h want %h", a, d, ref_byte(17'(a))); end
            tick(1);
        end
        tick(12);
        n_vec++; if (first_lat != 7) begin n_err++; $display("FAIL seq_first_latency: got %0d want 7", first_lat); end
        n_vec++; if (stalls != 0) begin n_err++; $display("FAIL seq_stalls: got %0d want 0", stalls); end
        exp_tags = '{15'd1, 15'd2, 15'd3, 15'd4};
        n_vec++;
        if (req_q.size() != 4) begin
            n_err++; $display("FAIL seq_requests: got %0d requests want 4", req_q.size());
        end else if (req_q[0] !== exp_tags[0] || req_q[1] !== exp_tags[1] ||
                     req_q[2] !== exp_tags[2] || req_q[3] !== exp_tags[3]) begin
            n_err++; $display("FAIL seq_requests: got %h %h %h %h want 1 2 3 4", req_q[0], req_q[1], req_q[2], req_q[3]);
        end
    endtask

    task automatic test_flush_mid_fill();
        int k;
        do_reset();
        mem_auto = 1'b0;
        rom_addr = 17'h00100;
        rom_cs   = 1'b1;
        tick(1);
        n_vec++; if (mem_cs !== 1'b1 || mem_addr !== 15'h040) begin n_err++; $display("FAIL flush_req: got cs %b addr %h want 1 040", mem_cs, mem_addr); end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(2);
        n_vec++; if (mem_cs !== 1'b1) begin n_err++; $display("FAIL flush_hold: mem_cs got %b want 1", mem_cs); end
        man_data = 32'hA5A55A5A;
        man_ok   = 1'b1;
        tick(1);
        man_ok = 1'b0;
        n_vec++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL flush_drop: mem_cs got %b want 0", mem_cs); end
        tick(1);
        n_vec++; if (mem_cs !== 1'b1 || mem_addr !== 15'h040) begin n_err++; $display("FAIL flush_rerequest: got cs %b addr %h want 1 040", mem_cs, mem_addr); end
        n_vec++; if (rom_ok !== 1'b0) begin n_err++; $display("FAIL flush_invalid: rom_ok got %b want 0", rom_ok); end
        $display("flush mid-fill: re-request addr %h", mem_addr);
        man_data = mem_words[15'h040];
        man_ok   = 1'b1;
        tick(1);
        man_ok = 1'b0;
        k = 0;
        while (!rom_ok && k < 10) begin tick(1); k++; end
        n_vec++; if (rom_ok !== 1'b1 || rom_data !== ref_byte(17'h00100)) begin n_err++; $display("FAIL flush_refill: ok %b data %h want 1 %h", rom_ok, rom_data, ref_byte(17'h00100)); end
        rom_cs = 1'b0;
        tick(1);
        mem_auto = 1'b1;
        tick(10);
    endtask

    task automatic test_wrap();
        int lat;
        logic [7:0] d;
        do_reset();
        mem_lat = 3;
        read_byte(17'h1FFFC, lat, d);
        n_vec++; if (d !== ref_byte(17'h1FFFC)) begin n_err++; $display("FAIL wrap_data: got %h want %h", d, ref_byte(17'h1FFFC)); end
        tick(10);
        n_vec++;
        if (req_q.size() != 2) begin
            n_err++; $display("FAIL wrap_prefetch: got %0d requests want 2", req_q.size());
        end else if (req_q[0] !== 15'h7FFF || req_q[1] !== 15'h0000) begin
            n_err++; $display("FAIL wrap_prefetch: got %h %h want 7fff 0000", req_q[0], req_q[1]);
        end
        read_byte(17'h00000, lat, d);
        n_vec++; if (lat != 1 || d !== ref_byte(17'h00000)) begin n_err++; $display("FAIL wrap_hit: lat %0d data %h want 1 %h", lat, d, ref_byte(17'h00000)); end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        logic [7:0] d;
        do_reset();
        mem_lat = 3;
        read_byte(17'h00300, lat, d);
        tick(20);
        mem_auto = 1'b0;
        rom_addr = 17'h00234;
        rom_cs   = 1'b1;
        tick(2);
        n_vec++; if (mem_cs !== 1'b1) begin n_err++; $display("FAIL rstfill_req: mem_cs got %b want 1", mem_cs); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (mem_cs !== 1'b0 || rom_ok !== 1'b0) begin n_err++; $display("FAIL rstfill_async: cs %b ok %b want 0 0", mem_cs, rom_ok); end
        rom_cs = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        man_data = 32'hFFFFFFFF;
        man_ok   = 1'b1;
        tick(1);
        man_ok = 1'b0;
        tick(1);
        n_vec++; if (mem_cs !== 1'b0 || rom_ok !== 1'b0) begin n_err++; $display("FAIL rstfill_late_ok: cs %b ok %b want 0 0", mem_cs, rom_ok); end
        mem_auto = 1'b1;
        req_q.delete();
        read_byte(17'h00300, lat, d);
        n_vec++; if (lat != 5 || d !== ref_byte(17'h00300)) begin n_err++; $display("FAIL rstfill_invalid: lat %0d data %h want 5 %h", lat, d, ref_byte(17'h00300)); end
        tick(10);
        read_byte(17'h00234, lat, d);
        n_vec++; if (lat != 5 || d !== ref_byte(17'h00234)) begin n_err++; $display("FAIL rstfill_refetch: lat %0d data %h want 5 %h", lat, d, ref_byte(17'h00234)); end
    endtask

    task automatic test_random();
        int lat, base, run;
        logic [16:0] a;
        logic [7:0] d;
        do_reset();
        unstable = 0;
        for (int r = 0; r < 40; r++) begin
            mem_lat = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 0) base = $urandom_range(0, 17'h003F0);
            else base = 17'h1FC00 + $urandom_range(0, 17'h003FF);
            run = $urandom_range(1, 10);
            for (int i = 0; i < run; i++) begin
                a = 17'(base + i);
                read_byte(a, lat, d);
                n_vec++; if (lat >= 200 || d !== ref_byte(a)) begin n_err++; $display("FAIL rand_read: addr %05h got %h lat %0d want %h", a, d, lat, ref_byte(a)); end
                tick($urandom_range(0, 3));
            end
            // Flush models a bank switch: memory contents change under the cache.
            if ($urandom_range(0, 4) == 0) begin
                for (int w = 0; w < 256; w++) begin
                    mem_words[w]             = $urandom;
                    mem_words[15'h7F00 + w]  = $urandom;
                end
                flush = 1'b1;
                tick(1);
                flush = 1'b0;
                $display("flush with bank switch");
            end
        end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL rand_addr_stable: %0d changes of mem_addr while mem_cs want 0", unstable); end
    endtask

    initial begin
        for (int w = 0; w < 32768; w++) mem_words[w] = $urandom;
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_sequential();
        test_flush_mid_fill();
        test_wrap();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
